// File: rtl/gpio_handover_ctrl.sv
// Wishbone-controlled GPIO pad arbiter: hands pad ownership between design
// slots through a drain/switch sequence so two slots never drive the pads at once.

module gpio_handover_ctrl #(
  parameter int NUM_TEAMS     = 1,
  parameter int GUARD_DEFAULT = 8
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_ni,
  input  logic                        wbs_stb_i,
  input  logic                        wbs_cyc_i,
  input  logic                        wbs_we_i,
  input  logic [3:0]                  wbs_sel_i,
  input  logic [31:0]                 wbs_dat_i,
  input  logic [31:0]                 wbs_adr_i,
  output logic                        wbs_ack_o,
  output logic [31:0]                 wbs_dat_o,
  input  logic [38*(NUM_TEAMS+1)-1:0] designs_gpio_out_flat,
  input  logic [38*(NUM_TEAMS+1)-1:0] designs_gpio_oeb_flat,
  output logic [37:0]                 gpio_out,
  output logic [37:0]                 gpio_oeb,
  output logic                        busy_o
);

  localparam int         SW       = (NUM_TEAMS < 1) ? 1 : $clog2(NUM_TEAMS + 1);
  localparam logic [7:0] MAX_SLOT = 8'(NUM_TEAMS);

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_DRAIN,
    ST_SWITCH
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   current_q, current_d;
  logic [SW-1:0]   target_q, target_d;
  logic [15:0]     guard_q, guard_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            bad_sel_q, bad_sel_d;
  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;
  logic [37:0]     gpio_out_q, gpio_out_d;
  logic [37:0]     gpio_oeb_q, gpio_oeb_d;

  logic            wb_req;
  logic            wb_wr;
  logic            pending;
  logic [31:0]     rdata;
  logic [37:0]     slot_out;
  logic [37:0]     slot_oeb;
  logic            unused_bits;

  assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

  // A new transfer is accepted only while ack is low, giving a one-cycle ack pulse.
  assign wb_req  = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign wb_wr   = wb_req & wbs_we_i;
  assign pending = (target_q != current_q);

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rdata = '0;
    unique case (wbs_adr_i[3:2])
      2'd0:    rdata = {24'd0, 8'(target_q)};
      2'd1:    rdata = {16'd0, guard_q};
      2'd2:    rdata = {16'd0, 8'(current_q), 5'd0, bad_sel_q, pending,
                        (state_q != ST_ACTIVE)};
      default: rdata = '0;
    endcase
  end

  always_comb begin
    target_d  = target_q;
    guard_d   = guard_q;
    bad_sel_d = bad_sel_q;
    ack_d     = wb_req;
    dat_d     = (wb_req && !wbs_we_i) ? rdata : 32'd0;
    if (wb_wr) begin
      unique case (wbs_adr_i[3:2])
        2'd0: begin
          if (wbs_sel_i[0]) begin
            if (wbs_dat_i[7:0] > MAX_SLOT) bad_sel_d = 1'b1;
            else                           target_d  = SW'(wbs_dat_i[7:0]);
          end
        end
        2'd1: begin
          if (wbs_sel_i[0]) guard_d[7:0]  = wbs_dat_i[7:0];
          if (wbs_sel_i[1]) guard_d[15:8] = wbs_dat_i[15:8];
        end
        2'd2: begin
          if (wbs_sel_i[0] && wbs_dat_i[2]) bad_sel_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Handover sequencing; decisions use pre-edge register values, so a bus
  // write landing on the same edge only takes effect from the next cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    current_d = current_q;
    unique case (state_q)
      ST_ACTIVE: begin
        if (pending) begin
          state_d = ST_DRAIN;
          cnt_d   = (guard_q == 16'd0) ? 16'd1 : guard_q;
        end
      end
      ST_DRAIN: begin
        if (cnt_q <= 16'd1) begin
          state_d = ST_SWITCH;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_SWITCH: begin
        current_d = target_q;
        state_d   = ST_ACTIVE;
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  always_comb begin
    slot_out = '0;
    slot_oeb = '1;
    for (int i = 0; i <= NUM_TEAMS; i++) begin
      if (int'(current_d) == i) begin
        slot_out = designs_gpio_out_flat[i*38 +: 38];
        slot_oeb = designs_gpio_oeb_flat[i*38 +: 38];
      end
    end
  end

  // Pads are released on the same edge the FSM leaves ACTIVE, and pick up the
  // new owner on the edge it re-enters, so there is no overlap cycle.
  always_comb begin
    gpio_out_d = '0;
    gpio_oeb_d = '1;
    if (state_d == ST_ACTIVE) begin
      gpio_out_d = slot_out;
      gpio_oeb_d = slot_oeb;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q    <= ST_ACTIVE;
      current_q  <= '0;
      target_q   <= '0;
      guard_q    <= 16'(GUARD_DEFAULT);
      cnt_q      <= '0;
      bad_sel_q  <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      gpio_out_q <= '0;
      gpio_oeb_q <= '1;
    end else begin
      state_q    <= state_d;
      current_q  <= current_d;
      target_q   <= target_d;
      guard_q    <= guard_d;
      cnt_q      <= cnt_d;
      bad_sel_q  <= bad_sel_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      gpio_out_q <= gpio_out_d;
      gpio_oeb_q <= gpio_oeb_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign gpio_out  = gpio_out_q;
  assign gpio_oeb  = gpio_oeb_q;
  assign busy_o    = (state_q != ST_ACTIVE);

endmodule
